// File: rtl/refill_collector_if.sv
// Handshake bundle for refill_collector: request, AXI-style read address/data, line write-out.
// REFILL_CRIT_WORD_EN adds the critical-word outputs.
interface refill_collector_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int BEATS  = 4
);
   localparam int LINE_W = WORD_W * BEATS;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              r_valid;
   logic              r_ready;
   logic [WORD_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_last;
   logic              line_we;
   logic [LINE_W-1:0] line_data;
   logic              line_err;
   logic              busy;
`ifdef REFILL_CRIT_WORD_EN
   logic              crit_valid;
   logic [WORD_W-1:0] crit_data;
`endif

   modport master (
      input  req_valid, req_addr, ar_ready, r_valid, r_data, r_resp, r_last,
      output req_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
             line_we, line_data, line_err, busy
`ifdef REFILL_CRIT_WORD_EN
      , output crit_valid, crit_data
`endif
   );

   modport slave (
      output req_valid, req_addr, ar_ready, r_valid, r_data, r_resp, r_last,
      input  req_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
             line_we, line_data, line_err, busy
`ifdef REFILL_CRIT_WORD_EN
      , input crit_valid, crit_data
`endif
   );
endinterface

// File: rtl/refill_collector.sv
// Single-outstanding cache line refill: one read burst, beats assembled into a line, one-cycle write strobe.
// REFILL_CRIT_WORD_EN selects a critical-word-first WRAP burst and adds crit_valid/crit_data.
module refill_collector #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int BEATS  = 4
) (
   input  logic               clk,
   input  logic               rstn,
   refill_collector_if.master bus
);
   localparam int CW       = $clog2(BEATS);
   localparam int BYTE_OFF = $clog2(WORD_W / 8);
   localparam int LINE_OFF = BYTE_OFF + CW;
`ifdef REFILL_CRIT_WORD_EN
   localparam int AR_OFF = BYTE_OFF;
   localparam logic [1:0] BURST = 2'b10;
`else
   localparam int AR_OFF = LINE_OFF;
   localparam logic [1:0] BURST = 2'b01;
`endif
   localparam logic [ADDR_W-1:0] AR_MASK = ~((ADDR_W'(1) << AR_OFF) - ADDR_W'(1));

   typedef enum logic [1:0] {IDLE, ADDR, RECV, DONE} state_t;

   state_t                        state, nxt;
   logic                          live;
   logic [ADDR_W-1:0]             addr_q;
   logic [CW-1:0]                 cnt, start, slot;
   logic                          err;
   logic [BEATS-1:0][WORD_W-1:0]  line_q;
   logic                          accept, beat, last_beat;

   assign accept    = (state == IDLE) && live && bus.req_valid;
   assign beat      = (state == RECV) && bus.r_valid;
   assign last_beat = (cnt == CW'(BEATS - 1));
`ifdef REFILL_CRIT_WORD_EN
   assign start = addr_q[LINE_OFF-1:BYTE_OFF];
`else
   assign start = '0;
`endif
   assign slot = start + cnt;

   // live holds req_ready low while reset is asserted even though the FSM sits in IDLE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= nxt;
         live  <= 1'b1;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = ADDR;
         ADDR:    if (bus.ar_ready) nxt = RECV;
         RECV:    if (beat && last_beat) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.ar_valid  = 1'b0;
      bus.r_ready   = 1'b0;
      bus.line_we   = 1'b0;
      bus.line_err  = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         IDLE: begin
            bus.req_ready = live;
            bus.busy      = 1'b0;
         end
         ADDR:    bus.ar_valid = 1'b1;
         RECV:    bus.r_ready  = 1'b1;
         DONE: begin
            bus.line_we  = 1'b1;
            bus.line_err = err;
         end
         default: bus.busy = 1'b0;
      endcase
   end

   // termination is by cnt alone; r_last only feeds the sticky error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q <= '0;
         cnt    <= '0;
         err    <= 1'b0;
         line_q <= '0;
      end else if (accept) begin
         addr_q <= bus.req_addr;
         cnt    <= '0;
         err    <= 1'b0;
      end else if (beat) begin
         line_q[slot] <= bus.r_data;
         cnt          <= cnt + 1'b1;
         if (bus.r_resp != 2'b00 || bus.r_last != last_beat) err <= 1'b1;
      end
   end

   assign bus.ar_addr   = addr_q & AR_MASK;
   assign bus.ar_len    = 8'(BEATS - 1);
   assign bus.ar_size   = 3'b010;
   assign bus.ar_burst  = BURST;
   assign bus.line_data = line_q;

`ifdef REFILL_CRIT_WORD_EN
   logic              crit_valid_q;
   logic [WORD_W-1:0] crit_data_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
      end else begin
         crit_valid_q <= beat && (cnt == '0);
         if (beat && cnt == '0) crit_data_q <= bus.r_data;
      end
   end

   assign bus.crit_valid = crit_valid_q;
   assign bus.crit_data  = crit_data_q;
`endif
endmodule

// File: tb/tb_refill_collector.sv
// Scoreboard bench for refill_collector: acts as requester and memory, checks each written line.
module tb_refill_collector;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef REFILL_CRIT_WORD_EN
   localparam bit CRIT = 1'b1;
   localparam logic [1:0] EXP_BURST = 2'b10;
`else
   localparam bit CRIT = 1'b0;
   localparam logic [1:0] EXP_BURST = 2'b01;
`endif

   typedef struct {
      logic [127:0] data;
      logic         err;
   } exp_t;
   exp_t sbq[$];

   refill_collector_if #(.ADDR_W(32), .WORD_W(32), .BEATS(4)) bus ();
   refill_collector #(.ADDR_W(32), .WORD_W(32), .BEATS(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   // d/resp/last are indexed by beat order (element 0 = first beat)
   task automatic run_refill(input logic [31:0] addr, input logic [3:0][31:0] d,
                             input logic [3:0][1:0] resp, input logic [3:0] last,
                             input int ar_dly, input int gap, input bit hold,
                             input bit chk_lat, input string tag);
      exp_t e, got;
      logic [3:0][31:0] ln;
      logic [1:0] st;
      logic [31:0] exp_ar;
      int t0, n;
      st = CRIT ? addr[3:2] : 2'd0;
      exp_ar = CRIT ? {addr[31:2], 2'b00} : {addr[31:4], 4'h0};
      ln = '0;
      e.err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ln[2'(st + 2'(i))] = d[i];
         if (resp[i] != 2'b00) e.err = 1'b1;
         if (last[i] != (i == 3)) e.err = 1'b1;
      end
      e.data = ln;
      sbq.push_back(e);

      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready timeout: got %b want 1", tag, bus.req_ready);
         bus.req_valid = 1'b0;
         sbq.delete();
         return;
      end
      t0 = cyc;
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;

      checks++;
      if (bus.ar_valid !== 1'b1) begin
         errors++; $display("FAIL %s ar_valid: got %b want 1", tag, bus.ar_valid);
      end
      checks++;
      if (bus.ar_addr !== exp_ar || bus.ar_len !== 8'd3 || bus.ar_burst !== EXP_BURST) begin
         errors++;
         $display("FAIL %s ar fields: addr %h len %0d burst %b want addr %h len 3 burst %b",
                  tag, bus.ar_addr, bus.ar_len, bus.ar_burst, exp_ar, EXP_BURST);
      end
      repeat (ar_dly) @(negedge clk);
      if (ar_dly > 0) begin
         checks++;
         if (bus.ar_valid !== 1'b1 || bus.ar_addr !== exp_ar) begin
            errors++;
            $display("FAIL %s ar stall hold: valid %b addr %h want 1 %h", tag, bus.ar_valid, bus.ar_addr, exp_ar);
         end
      end
      bus.ar_ready = 1'b1;
      @(negedge clk);
      bus.ar_ready = 1'b0;

      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!bus.r_ready && n < 20) begin @(negedge clk); n++; end
         checks++;
         if (bus.r_ready !== 1'b1) begin
            errors++; $display("FAIL %s r_ready timeout beat %0d", tag, i);
         end
         if (hold) begin
            checks++;
            if (bus.req_ready !== 1'b0) begin
               errors++; $display("FAIL %s req_ready while busy: got %b want 0", tag, bus.req_ready);
            end
         end
         bus.r_valid = 1'b1;
         bus.r_data  = d[i];
         bus.r_resp  = resp[i];
         bus.r_last  = last[i];
         @(negedge clk);
         bus.r_valid = 1'b0;
         bus.r_resp  = 2'b00;
         bus.r_last  = 1'b0;
`ifdef REFILL_CRIT_WORD_EN
         if (i == 0) begin
            checks++;
            if (bus.crit_valid !== 1'b1 || bus.crit_data !== d[0]) begin
               errors++;
               $display("FAIL %s crit: valid %b data %h want 1 %h", tag, bus.crit_valid, bus.crit_data, d[0]);
            end
         end
`endif
         if (i < 3) repeat (gap) @(negedge clk);
      end
      if (hold) bus.req_valid = 1'b0;

      // one cycle after the final beat
      checks++;
      if (bus.line_we !== 1'b1 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s line_we: we %b req_ready %b want 1 0", tag, bus.line_we, bus.req_ready);
      end
      got = sbq.pop_front();
      checks++;
      if (bus.line_data !== got.data) begin
         errors++; $display("FAIL %s line_data: got %h want %h", tag, bus.line_data, got.data);
      end
      checks++;
      if (bus.line_err !== got.err) begin
         errors++; $display("FAIL %s line_err: got %b want %b", tag, bus.line_err, got.err);
      end
      if (chk_lat) begin
         checks++;
         if (cyc - t0 != 6) begin
            errors++; $display("FAIL %s latency: got %0d want 6", tag, cyc - t0);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.line_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.line_data !== got.data) begin
         errors++;
         $display("FAIL %s after done: we %b req_ready %b busy %b data %h want 0 1 0 %h",
                  tag, bus.line_we, bus.req_ready, bus.busy, bus.line_data, got.data);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (bus.req_ready !== 1'b0 || bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0 || bus.line_we !== 1'b0 ||
          bus.line_err !== 1'b0 || bus.busy !== 1'b0 || bus.line_data !== 128'h0 || bus.ar_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset outputs: rr %b av %b rdy %b we %b err %b busy %b data %h addr %h want all 0",
                  bus.req_ready, bus.ar_valid, bus.r_ready, bus.line_we, bus.line_err, bus.busy, bus.line_data, bus.ar_addr);
      end
      checks++;
      if (bus.ar_len !== 8'd3 || bus.ar_size !== 3'b010 || bus.ar_burst !== EXP_BURST) begin
         errors++;
         $display("FAIL reset constants: len %0d size %b burst %b want 3 010 %b", bus.ar_len, bus.ar_size, bus.ar_burst, EXP_BURST);
      end
`ifdef REFILL_CRIT_WORD_EN
      checks++;
      if (bus.crit_valid !== 1'b0 || bus.crit_data !== 32'h0) begin
         errors++; $display("FAIL reset crit: %b %h want 0 0", bus.crit_valid, bus.crit_data);
      end
`endif
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL reset release req_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_basic();
      run_refill(32'h0000_1234, {32'h44, 32'h33, 32'h22, 32'h11}, '0, 4'b1000, 0, 0, 1'b0, 1'b1, "basic");
      if (!CRIT) begin
         checks++;
         if (bus.line_data !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            errors++; $display("FAIL basic literal line: got %h want 00000044000000330000002200000011", bus.line_data);
         end
      end
   endtask

   task automatic test_backpressure();
      run_refill(32'h0000_1234, {32'h44, 32'h33, 32'h22, 32'h11}, '0, 4'b1000, 3, 1, 1'b1, 1'b0, "backpressure");
   endtask

   task automatic test_error();
      run_refill(32'h0000_4000, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, {2'b00, 2'b10, 2'b00, 2'b00},
                 4'b1000, 0, 0, 1'b0, 1'b0, "resp_err");
      run_refill(32'h0000_4010, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, '0, 4'b1000, 0, 0, 1'b0, 1'b0, "clean_after_err");
   endtask

   task automatic test_rlast();
      run_refill(32'h0000_5000, {32'h54, 32'h53, 32'h52, 32'h51}, '0, 4'b1010, 0, 0, 1'b0, 1'b0, "rlast_early");
      run_refill(32'h0000_5020, {32'h64, 32'h63, 32'h62, 32'h61}, '0, 4'b0000, 0, 1, 1'b0, 1'b0, "rlast_missing");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_2000;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.ar_ready  = 1'b1;
      @(negedge clk);
      bus.ar_ready  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.r_valid = 1'b1;
         bus.r_data  = 32'hBEEF_0000 + i;
         @(negedge clk);
      end
      bus.r_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.r_ready !== 1'b1) begin
         errors++; $display("FAIL midreset pre: busy %b r_ready %b want 1 1", bus.busy, bus.r_ready);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.r_ready !== 1'b0 || bus.line_data !== 128'h0 || bus.req_ready !== 1'b0 ||
          bus.line_we !== 1'b0 || bus.ar_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset async: busy %b r_ready %b data %h req_ready %b want 0 0 0 0",
                  bus.busy, bus.r_ready, bus.line_data, bus.req_ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL midreset release req_ready: got %b want 1", bus.req_ready);
      end
      run_refill(32'h0000_2000, {32'h0A04, 32'h0A03, 32'h0A02, 32'h0A01}, '0, 4'b1000, 0, 0, 1'b0, 1'b1, "after_midreset");
   endtask

   task automatic test_back_to_back();
      logic [3:0][31:0] d;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) d[i] = $urandom;
         run_refill($urandom, d, '0, 4'b1000, k % 2, (k + 1) % 3, 1'b0, 1'b0, "back_to_back");
      end
   endtask

`ifdef REFILL_CRIT_WORD_EN
   task automatic test_crit();
      run_refill(32'h0000_1238, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, '0, 4'b1000, 0, 0, 1'b0, 1'b1, "crit");
      checks++;
      if (bus.line_data !== {32'hBBBB, 32'hAAAA, 32'hDDDD, 32'hCCCC}) begin
         errors++; $display("FAIL crit literal line: got %h want {B,A,D,C}", bus.line_data);
      end
   endtask
`endif

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.ar_ready  = 1'b0;
      bus.r_valid   = 1'b0;
      bus.r_data    = '0;
      bus.r_resp    = 2'b00;
      bus.r_last    = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_rlast();
      test_reset_mid();
      test_back_to_back();
`ifdef REFILL_CRIT_WORD_EN
      test_crit();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
